// File: rtl/dice_roll_sequencer.sv
// rtl/dice_roll_sequencer.sv - roll timing controller: debounce, tumble, decelerating settle, face hold
// Defining AUTO_BLANK_EN adds BLANK_CYCLES and turns the LEDs off after a quiet period in SHOW.

module dice_roll_sequencer #(
  parameter int DEB_CYCLES   = 8,
  parameter int TICK_FAST    = 4,
  parameter int SETTLE_STEPS = 4,
  parameter int CNT_W        = 16
`ifdef AUTO_BLANK_EN
  ,
  parameter int BLANK_CYCLES = 1024
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ROLL,
  input  logic [2:0] rng_face,
  output logic       rng_step,
  output logic [2:0] face_out,
  output logic       show,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TUMBLE = 2'd1,
    SETTLE = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam int                STEP_W   = $clog2(SETTLE_STEPS + 2);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TICK_C   = CNT_W'(TICK_FAST);
  localparam logic [STEP_W-1:0] LAST_K   = STEP_W'(SETTLE_STEPS - 1);
  localparam logic [STEP_W-1:0] ONE_K    = STEP_W'(1);
  localparam logic [STEP_W-1:0] TWO_K    = STEP_W'(2);

  if ((64'(TICK_FAST) << SETTLE_STEPS) > ((64'd1 << CNT_W) - 64'd1)) begin : g_cnt_w_too_small
    $error("dice_roll_sequencer: CNT_W cannot hold TICK_FAST<<SETTLE_STEPS");
  end

  state_t              state_q, state_d;
  logic                roll_meta_q, roll_sync_q;
  logic [CNT_W-1:0]    deb_q, deb_d;
  logic [CNT_W-1:0]    tick_q, tick_d;
  logic [STEP_W-1:0]   k_q, k_d;
  logic                done_q, done_d;
  logic                cap_q;
  logic [2:0]          face_q;
  logic                deb_level, deb_match, deb_hit, tick_zero, face_ok;

  // The debouncer looks for a press outside TUMBLE and for a release inside it.
  assign deb_level = (state_q != TUMBLE);
  assign deb_match = (roll_sync_q == deb_level);
  assign deb_hit   = deb_match && (deb_q == DEB_LAST);
  assign tick_zero = (tick_q == '0);
  assign face_ok   = (rng_face != 3'd0) && (rng_face != 3'd7);

`ifdef AUTO_BLANK_EN
  localparam int                 BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [BLANK_W-1:0] BLANK_C = BLANK_W'(BLANK_CYCLES);

  logic [BLANK_W-1:0] blank_q, blank_d;

  always_comb begin
    blank_d = '0;
    if (state_q == SHOW) begin
      blank_d = (blank_q == BLANK_C) ? blank_q : blank_q + BLANK_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      roll_meta_q <= 1'b0;
      roll_sync_q <= 1'b0;
      deb_q       <= '0;
      tick_q      <= '0;
      k_q         <= '0;
      done_q      <= 1'b0;
      cap_q       <= 1'b0;
      face_q      <= 3'd1;
    end else begin
      roll_meta_q <= ROLL;
      roll_sync_q <= roll_meta_q;
      deb_q       <= deb_d;
      tick_q      <= tick_d;
      k_q         <= k_d;
      done_q      <= done_d;
      cap_q       <= rng_step;
      face_q      <= face_out;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = '0;
    tick_d  = tick_q;
    k_d     = k_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, SHOW: begin
        if (deb_hit) begin
          state_d = TUMBLE;
          tick_d  = ONE_C;
        end else if (deb_match) begin
          deb_d = deb_q + ONE_C;
        end
      end
      TUMBLE: begin
        tick_d = tick_zero ? (TICK_C - ONE_C) : (tick_q - ONE_C);
        if (deb_hit) begin
          state_d = SETTLE;
          tick_d  = TICK_C << 1;
          k_d     = '0;
        end else if (deb_match) begin
          deb_d = deb_q + ONE_C;
        end
      end
      SETTLE: begin
        // Each settle interval doubles; the counter holds the interval minus one after a step.
        if (!tick_zero) begin
          tick_d = tick_q - ONE_C;
        end else if (k_q == LAST_K) begin
          state_d = SHOW;
          done_d  = 1'b1;
          tick_d  = '0;
        end else begin
          k_d    = k_q + ONE_K;
          tick_d = (TICK_C << (k_q + TWO_K)) - ONE_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rng_step = tick_zero && ((state_q == TUMBLE) || (state_q == SETTLE));
    busy     = (state_q == TUMBLE) || (state_q == SETTLE);
    face_out = (cap_q && face_ok) ? rng_face : face_q;
    done     = done_q;
    show     = (state_q != IDLE);
`ifdef AUTO_BLANK_EN
    if ((state_q == SHOW) && (blank_q == BLANK_C)) begin
      show = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// tb/tb_dice_roll_sequencer.sv - scoreboard bench for dice_roll_sequencer

module tb_dice_roll_sequencer;

    localparam int TICK = 4;
    localparam int SST  = 4;
`ifdef AUTO_BLANK_EN
    localparam int BLANK_EXP = 0;
`else
    localparam int BLANK_EXP = 1;
`endif

    typedef struct {
        int cyc;
        int face;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ROLL;
    logic [2:0] rng_face;
    logic       rng_step;
    logic [2:0] face_out;
    logic       show;
    logic       busy;
    logic       done;

    int  cyc = 0;
    int  chk_cnt = 0;
    int  err_cnt = 0;
    int  step_seen = 0;
    int  done_seen = 0;
    int  exp_face = 1;
    int  chk_face = 0;
    bit  sb_en = 1'b0;
    bit  feed_pending = 1'b0;
    bit  chk_face_valid = 1'b0;
    ev_t exp_steps[$];
    ev_t exp_done[$];
    int  face_plan[$];

`ifdef AUTO_BLANK_EN
    dice_roll_sequencer #(.BLANK_CYCLES(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ROLL     (ROLL),
        .rng_face (rng_face),
        .rng_step (rng_step),
        .face_out (face_out),
        .show     (show),
        .busy     (busy),
        .done     (done)
    );
`else
    dice_roll_sequencer dut (
        .CLK      (CLK),
        .RST      (RST),
        .ROLL     (ROLL),
        .rng_face (rng_face),
        .rng_step (rng_step),
        .face_out (face_out),
        .show     (show),
        .busy     (busy),
        .done     (done)
    );
`endif

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    always @(posedge CLK) begin
        if (feed_pending) begin
            #1;
            feed_pending = 1'b0;
            if (face_plan.size() > 0) rng_face = 3'(face_plan.pop_front());
            else rng_face = 3'd2;
        end
    end

    always @(negedge CLK) begin
        ev_t e;
        if (sb_en && chk_face_valid) begin
            chk_face_valid = 1'b0;
            check_eq("cap_face", int'(face_out), chk_face);
        end
        if (sb_en) check_eq("step_done_excl", int'(rng_step && done), 0);
        if (rng_step) begin
            step_seen++;
            feed_pending = 1'b1;
            if (sb_en) begin
                if (exp_steps.size() == 0) begin
                    check_eq("step_extra", cyc, -1);
                end else begin
                    e = exp_steps.pop_front();
                    check_eq("step_cyc", cyc, e.cyc);
                    chk_face = e.face;
                    chk_face_valid = 1'b1;
                end
            end
        end
        if (done) begin
            done_seen++;
            if (sb_en) begin
                if (exp_done.size() == 0) begin
                    check_eq("done_extra", cyc, -1);
                end else begin
                    e = exp_done.pop_front();
                    check_eq("done_cyc", cyc, e.cyc);
                    check_eq("done_face", int'(face_out), e.face);
                    check_eq("done_busy", int'(busy), 0);
                    check_eq("done_show", int'(show), 1);
                end
            end
        end
    end

    task automatic do_roll(input int hold, input int glitch_at, input int bad_at,
                           input int last_face, output int done_cyc);
        int p, a, t, n, v, ef;
        int cycs[$];
        p = cyc;
        a = p + hold + 10;
        for (int c = p + 11; c < a; c += 4) cycs.push_back(c);
        t = a;
        for (int k = 1; k <= SST; k++) begin
            t += TICK << k;
            cycs.push_back(t);
        end
        n  = cycs.size();
        ef = exp_face;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) v = last_face;
            else if (i == bad_at) v = 7;
            else v = (i % 6) + 1;
            face_plan.push_back(v);
            if (v >= 1 && v <= 6) ef = v;
            exp_steps.push_back('{cycs[i], ef});
        end
        exp_face = ef;
        done_cyc = cycs[n-1] + 1;
        exp_done.push_back('{done_cyc, ef});

        ROLL = 1'b1;
        goto(p + 9);
        check_eq("pre_accept_busy", int'(busy), 0);
        goto(p + 10);
        check_eq("accept_busy", int'(busy), 1);
        check_eq("accept_show", int'(show), 1);
        if (glitch_at >= 0) begin
            goto(p + glitch_at);
            ROLL = 1'b0;
            goto(p + glitch_at + 5);
            ROLL = 1'b1;
        end
        goto(p + hold);
        ROLL = 1'b0;
        goto(a);
        check_eq("settle_busy", int'(busy), 1);
        goto(done_cyc + 1);
        check_eq("show_busy", int'(busy), 0);
    endtask

    initial begin
        int dc, c0, d0, s0;
        RST = 1'b0;
        ROLL = 1'b0;
        rng_face = 3'd2;
        @(negedge CLK);
        for (int i = 0; i < 12; i++) begin
            ROLL = (i % 3 == 0);
            @(negedge CLK);
        end
        check_eq("rst_face", int'(face_out), 1);
        check_eq("rst_show", int'(show), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_steps", step_seen, 0);
        ROLL = 1'b0;
        RST = 1'b1;
        goto(cyc + 4);

        c0 = cyc;
        ROLL = 1'b1;
        goto(c0 + 5);
        ROLL = 1'b0;
        goto(c0 + 25);
        check_eq("glitch_busy", int'(busy), 0);
        check_eq("glitch_show", int'(show), 0);
        check_eq("glitch_steps", step_seen, 0);
        check_eq("glitch_face", int'(face_out), 1);

        sb_en = 1'b1;
        do_roll(30, -1, -1, 3, dc);
        goto(dc + 5);
        do_roll(40, 20, 2, 5, dc);
        goto(dc + 15);
        check_eq("blank_pre", int'(show), 1);
        goto(dc + 16);
        check_eq("blank_edge", int'(show), BLANK_EXP);
        check_eq("face_held", int'(face_out), 5);
        check_eq("held_busy", int'(busy), 0);
        goto(dc + 30);
        do_roll(20, -1, 3, 0, dc);
        goto(dc + 5);
        check_eq("face_final_rejected", int'(face_out), exp_face);
        check_eq("sb_steps_drained", exp_steps.size(), 0);
        check_eq("sb_done_drained", exp_done.size(), 0);
        sb_en = 1'b0;

        c0 = cyc;
        ROLL = 1'b1;
        goto(c0 + 20);
        ROLL = 1'b0;
        goto(c0 + 60);
        check_eq("mid_settle_busy", int'(busy), 1);
        d0 = done_seen;
        s0 = step_seen;
        RST = 1'b0;
        #1;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_show", int'(show), 0);
        check_eq("abort_face", int'(face_out), 1);
        check_eq("abort_step", int'(rng_step), 0);
        check_eq("abort_done", int'(done), 0);
        goto(cyc + 5);
        RST = 1'b1;
        goto(cyc + 150);
        check_eq("abort_no_done", done_seen, d0);
        check_eq("abort_no_step", step_seen, s0);
        check_eq("abort_idle_busy", int'(busy), 0);
        check_eq("abort_idle_show", int'(show), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dice_roll_sequencer.md
Name: dice_roll_sequencer

Overview:
Controller that sequences the dice datapath: debounces the ROLL button, drives the random-source step strobe during a fast "tumble" while ROLL is held, then a decelerating "settle" after release, and captures and holds the final face. It sits between the io_in pins and the face-generator/LED-decoder datapath, and owns all roll timing.

Parameters:
DEB_CYCLES, 8, consecutive stable synchronized samples needed to accept a press or release
TICK_FAST, 4, step interval in cycles during TUMBLE
SETTLE_STEPS, 4, number of decelerating steps after release
CNT_W, 16, interval/debounce counter width; must hold TICK_FAST<<SETTLE_STEPS (simulation $error if not)

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-low
ROLL  input  1  raw button, asynchronous to CLK
rng_face  input  3  current face from random datapath, valid 1..6
rng_step  output  1  one-cycle strobe: datapath advances to a new face
face_out  output  3  face presented to LED decoder
show  output  1  LED enable
busy  output  1  high in TUMBLE and SETTLE
done  output  1  one-cycle pulse when the final face is captured

Behaviour:
- Reset (RST low, async): state IDLE, face_out=1, show=0, busy=0, rng_step=0, done=0, all counters 0. Reset mid-roll aborts immediately; no done.
- ROLL passes a 2-flop synchronizer; only the synchronized value is used.
- States: IDLE, TUMBLE, SETTLE, SHOW.
- IDLE/SHOW: debounce counter increments while sync ROLL=1, clears on 0; reaching DEB_CYCLES = press accepted -> TUMBLE. First rng_step is the cycle after acceptance (2+DEB_CYCLES+1 cycles after ROLL rises).
- TUMBLE: busy=1, show=1; rng_step every TICK_FAST cycles. Release debounce: counter increments while sync ROLL=0, clears on 1; reaching DEB_CYCLES -> SETTLE. Glitches shorter than DEB_CYCLES are ignored.
- SETTLE: busy=1, show=1; step k (k=1..SETTLE_STEPS) issued TICK_FAST<<k cycles after the previous step (step 1 timed from release acceptance). ROLL is ignored in SETTLE.
- Face capture: face_out loads rng_face in the cycle after each rng_step. Values 0 or 7 are rejected; face_out holds its previous value.
- Final settle step: in the cycle after it, face_out shows the final face, done=1 for one cycle, and the state goes to SHOW (busy=0, show=1).
- SHOW: face_out held. A new accepted press -> TUMBLE (re-roll).
- rng_step and done never assert in the same cycle. rng_step never asserts in IDLE or SHOW.

Optional Feature:
AUTO_BLANK_EN: when defined, adds parameter BLANK_CYCLES (default 1024). After BLANK_CYCLES cycles in SHOW with no accepted press, show goes to 0 and face_out is retained. An accepted press resumes normally. When not defined, show stays 1 in SHOW indefinitely, and IDLE is the only state with show=0.

Test Plan:
- Reset: hold RST=0, toggle ROLL -> face_out=1, show=0, busy=0, no rng_step.
- Press ROLL at cycle 0 (defaults) -> first rng_step at cycle 11, then every 4 cycles. busy=1 and show=1 from acceptance.
- 5-cycle ROLL glitch in IDLE -> no state change and no rng_step. 5-cycle low glitch during TUMBLE -> tumble continues.
- Release after tumble -> settle steps at +8, +16, +32, +64 cycles (cumulative 120 from release acceptance). Final face and done both visible at cycle 121, busy=0, state SHOW.
- rng_face driven to 7 on a step -> face_out unchanged. rng_face=5 on the final step -> face_out=5 held in SHOW. A new press re-enters TUMBLE.
- Assert RST mid-SETTLE -> outputs return to reset values immediately and no done pulse. With AUTO_BLANK_EN and BLANK_CYCLES=16: show=0 exactly 16 cycles after done, face_out retained.
